bin_to_bcd_seq: RTL and testbench

- Sequential shift-and-add-3 ("double dabble") binary-to-BCD converter.
- Sits directly upstream of the per-digit BCD-to-7-segment decoders. Each 4-bit digit slice of its bcd output drives one decoder.
- Converts one binary value per start request, using one shift per clock, with a start/busy/done handshake.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_digit_adj.sv | 17 +
 rtl/bin_to_bcd_seq.sv | 110 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam int unsigned DIGIT_W    = 4;
    localparam logic [3:0]  ADJ_THRESH = 4'd5;
    localparam logic [3:0]  ADJ_ADD    = 4'd3;
    localparam logic [3:0]  BCD_NINE   = 4'd9;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    // Inputs are always valid BCD (0..9), so the sum never exceeds 12.
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= ADJ_THRESH) begin
            digit_o = digit_i + ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake.
// Optional build macro BIN_TO_BCD_SATURATE_EN: on overflow, bcd saturates to all nines.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                      overflow
);

    localparam int unsigned      SCR_W    = DIGIT_W * DIGITS;
    localparam int unsigned      CNT_W    = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   shreg_q, shreg_d;
    logic [SCR_W-1:0]   scr_q, scr_d;
    logic               sticky_q, sticky_d;
    logic [SCR_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic [SCR_W-1:0]   scr_adj;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (scr_q[g*DIGIT_W +: DIGIT_W]),
            .digit_o (scr_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        scr_d    = scr_q;
        sticky_d = sticky_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d  = bin;
                    scr_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                {scr_d, shreg_d} = {scr_adj, shreg_q} << 1;
                // A 1 leaving the top digit means the value no longer fits.
                sticky_d = sticky_q | scr_adj[SCR_W-1];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
`ifdef BIN_TO_BCD_SATURATE_EN
                bcd_d = sticky_q ? {DIGITS{BCD_NINE}} : scr_q;
`else
                bcd_d = scr_q;
`endif
                ovf_d   = sticky_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            scr_q    <= '0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            scr_q    <= scr_d;
            sticky_q <= sticky_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed, table-driven bench for bin_to_bcd_seq (BIN_W=14, DIGITS=4).
module tb_bin_to_bcd_seq;

    localparam int unsigned BIN_W  = 14;
    localparam int unsigned DIGITS = 4;
`ifdef BIN_TO_BCD_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [BIN_W-1:0]  bin;
    logic              busy;
    logic              done;
    logic [15:0]       bcd;
    logic              overflow;

    int unsigned total  = 0;
    int unsigned passed = 0;

    typedef struct {
        int unsigned bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    bin_to_bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    function automatic logic [15:0] dec4(input int unsigned v);
        int unsigned r;
        r = v % 10000;
        return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
    endfunction

    // Launch one conversion from IDLE and check latency, result and handshake.
    task automatic run_conv(input string name, input int unsigned v,
                            input logic [15:0] exp_bcd, input logic exp_ovf);
        int k;
        k     = 0;
        start = 1'b1;
        bin   = BIN_W'(v);
        tick();
        start = 1'b0;
        bin   = '1;
        check({name, " busy"}, 32'(busy), 32'd1);
        while (!done && k < 40) begin
            tick();
            k++;
        end
        check({name, " latency"}, 32'(k), 32'(BIN_W + 1));
        check({name, " bcd"}, 32'(bcd), 32'(exp_bcd));
        check({name, " ovf"}, 32'(overflow), 32'(exp_ovf));
        check({name, " idle at done"}, 32'(busy), 32'd0);
        tick();
        check({name, " done pulse"}, 32'(done), 32'd0);
        check({name, " bcd held"}, 32'(bcd), 32'(exp_bcd));
    endtask

    initial begin
        int ndone;
        int idx;

        vecs[0] = '{0,     16'h0000, 1'b0};
        vecs[1] = '{1234,  16'h1234, 1'b0};
        vecs[2] = '{9999,  16'h9999, 1'b0};
        vecs[3] = '{10000, SAT ? 16'h9999 : 16'h0000, 1'b1};
        vecs[4] = '{16383, SAT ? 16'h9999 : 16'h6383, 1'b1};
        vecs[5] = '{5,     16'h0005, 1'b0};
        vecs[6] = '{10,    16'h0010, 1'b0};
        vecs[7] = '{4095,  16'h4095, 1'b0};
        vecs[8] = '{8191,  16'h8191, 1'b0};
        vecs[9] = '{99,    16'h0099, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset bcd", 32'(bcd), 32'd0);
        check("reset ovf", 32'(overflow), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_conv($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].ovf);
        end

        // Starts while busy are ignored; only the edge-16 start is taken.
        ndone = 0;
        start = 1'b1;
        bin   = BIN_W'(42);
        tick();
        for (int e = 1; e <= 15; e++) begin
            start = (e == 3 || e == 15);
            bin   = (e == 3 || e == 15) ? BIN_W'(77) : BIN_W'(999 + e);
            tick();
            if (done) ndone++;
            if (e == 15) begin
                check("ignore done@15", 32'(done), 32'd1);
                check("ignore bcd 42", 32'(bcd), 32'h0042);
            end
        end
        check("ignore single done", 32'(ndone), 32'd1);
        start = 1'b1;
        bin   = BIN_W'(77);
        tick();
        start = 1'b0;
        bin   = BIN_W'(5);
        ndone = 0;
        for (int e = 17; e <= 31; e++) begin
            tick();
            if (done) ndone++;
            if (e == 31) begin
                check("restart done@31", 32'(done), 32'd1);
                check("restart bcd 77", 32'(bcd), 32'h0077);
            end
        end
        check("restart single done", 32'(ndone), 32'd1);
        tick();

        // Reset mid-conversion aborts without a done.
        run_conv("pre-reset 321", 321, 16'h0321, 1'b0);
        start = 1'b1;
        bin   = BIN_W'(5555);
        tick();
        start = 1'b0;
        for (int e = 1; e <= 6; e++) tick();
        #2;
        reset = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort bcd", 32'(bcd), 32'd0);
        check("abort ovf", 32'(overflow), 32'd0);
        tick();
        reset = 1'b0;
        ndone = 0;
        for (int e = 0; e < 24; e++) begin
            tick();
            if (done || bcd != 16'h0000) ndone++;
        end
        check("abort no done", 32'(ndone), 32'd0);
        run_conv("post-reset 8765", 8765, 16'h8765, 1'b0);

        // Start held high: one conversion per 16 cycles, bin sampled at accept.
        ndone = 0;
        start = 1'b1;
        for (int c = 0; c < 21 * 16; c++) begin
            bin = (c % 16 == 0) ? BIN_W'(c / 16) : BIN_W'(16383 - c);
            tick();
            if (done) begin
                idx = (c - 15) / 16;
                ndone++;
                check($sformatf("b2b phase %0d", c), 32'(c % 16), 32'd15);
                check($sformatf("b2b bcd %0d", idx), 32'(bcd), 32'(dec4(idx)));
            end
        end
        start = 1'b0;
        check("b2b done count", 32'(ndone), 32'd21);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
